sprite_motion_ctrl: RTL and testbench
=====================================

// Module: sprite_motion_ctrl
// PURPOSE
//  Parametrised multi-sprite motion controller, successor to the single-sprite mover.
//  Runs NUM_SPRITES independent movers from per-sprite keycodes, clamped to the screen.
//  Supports step mode (tap = one step, hold = auto-repeat) and continuous mode.
//  Collision undo: a flagged move is reverted and that direction is blocked until released.
//  Sits between the keycode/USB path and color_mapper/collision logic; updated once per frame_clk (vsync).
// PARAMETERS
//  NUM_SPRITES  2    number of independent sprites
//  COORD_W      10   coordinate width (bits)
//  X_MIN/X_MAX  0/639  screen bounds, X
//  Y_MIN/Y_MAX  0/479  screen bounds, Y
//  SIZE         30   half-extent; also driven on spriteS
//  STEP         1    pixels moved per step
//  X_START/Y_START  320/240  reset position
//  HOLD_FRAMES  8    frames a key is held before auto-repeat (step mode); >=1
// PORTS
//  frame_clk  in   1                      frame clock; the only clock
//  Reset      in   1                      synchronous, active-low reset
//  keycode    in   NUM_SPRITES*8          per-sprite keycode; sprite i = [8i+7:8i]
//  mode       in   1                      0 = step/auto-repeat, 1 = continuous
//  collision  in   NUM_SPRITES            1 = sprite i's current position collides
//  spriteX    out  NUM_SPRITES*COORD_W    X centres, packed as keycode
//  spriteY    out  NUM_SPRITES*COORD_W    Y centres
//  spriteS    out  COORD_W                = SIZE, constant
//  blocked    out  NUM_SPRITES            1 = sprite i in BLOCKED state
// BEHAVIOUR
//  - Reset low at a frame_clk edge puts every sprite at (X_START,Y_START), state IDLE,
//    hold counter 0, blocked 0. This applies mid-move too; collision is ignored that edge.
//  - Key decode: 8'h04 L, 8'h07 R, 8'h16 D, 8'h1A U; any other code = NONE.
//  - Latency: position moves on the same edge that samples the key. No one-frame-stale motion register.
//  - Next position is computed in COORD_W+1 signed arithmetic, then clamped.
//    X is clamped to [X_MIN+SIZE, X_MAX-SIZE] and Y to [Y_MIN+SIZE, Y_MAX-SIZE]; no wrap-around.
//  - Per-sprite FSM (prev_pos and last_dir are registered per sprite):
//    IDLE: dir!=NONE -> take a step, save prev_pos, set last_dir and state HELD, clear cnt.
//    HELD: on a step frame, save prev_pos and step; otherwise hold position.
//      Step mode: no step until cnt reaches HOLD_FRAMES, then step every frame.
//      Continuous mode: step every frame.
//      Change of dir: treat as a fresh press (step now, cnt=0). dir=NONE -> IDLE.
//    BLOCKED: no motion while dir==last_dir; dir==NONE -> IDLE; different dir -> fresh press.
//  - Collision in HELD (sprite moved on the previous edge): pos<=prev_pos, state BLOCKED, no step.
//    Collision beats a simultaneous key change.
//    Collision in IDLE or BLOCKED does not revert; the sprite stays where it is.
//  - A clamped step that produces no displacement still counts as a step. prev_pos is still saved.
//  - A mode change takes effect on the next edge; cnt is not cleared.
//  - Sprites are fully independent; no sprite-to-sprite interaction.
// STRUCTURE
//  - Package sprite_pkg:
//    dir_e {NONE,L,R,U,D}; keycode localparams KEY_A/D/S/W; state_e {IDLE,HELD,BLOCKED};
//    function decode_key(logic[7:0]) -> dir_e.
//  - Sub-module sprite_axis_unit: one sprite's FSM, hold counter, clamp and undo.
//  - Top level: generate-for over NUM_SPRITES, plus port packing.
// TESTING
//  1. Reset low 1 edge -> all sprites (320,240), blocked=0. Reset high with keycode 0 -> no motion.
//  2. Step mode, key 8'h07 held 12 frames.
//     -> X=321 at edge 1, flat until cnt=8, then +1 per frame. Release -> stays put.
//  3. Continuous mode, 8'h04 held from X=32 -> 31, 30, then 30 held (clamp at X_MIN+SIZE=30).
//     Same test on the right edge: clamp at 609.
//  4. 8'h1A from Y=240 -> 239; collision=1 on the next edge -> Y=240, blocked=1.
//     Still held -> no motion. Switch to 8'h16 -> Y=241, blocked=0.
//  5. Collision=1 on the same edge as a dir change -> revert wins, no step.
//     Collision=1 in IDLE -> position unchanged.
//  6. NUM_SPRITES=2: sprite0 8'h07, sprite1 8'h04 -> X0 +1, X1 -1.
//     collision[1] only -> only sprite1 reverts. Reset mid-repeat -> both back to centre.

Source files
------------

// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared types for the multi-sprite motion controller: move directions,
// per-sprite FSM states and the keyboard scan codes that select them.
package sprite_pkg;

  typedef enum logic [2:0] {NONE, L, R, U, D} dir_e;

  typedef enum logic [1:0] {IDLE, HELD, BLOCKED} state_e;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;

  function automatic dir_e decode_key(input logic [7:0] code);
    case (code)
      KEY_A:   return L;
      KEY_D:   return R;
      KEY_S:   return D;
      KEY_W:   return U;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Keycode/collision inputs and packed sprite position outputs between the
// USB keycode path, the motion controller and the colour mapper.
interface sprite_motion_ctrl_if #(
  parameter int NUM_SPRITES = 2,
  parameter int COORD_W     = 10
);

  logic [NUM_SPRITES*8-1:0]       keycode;
  logic                           mode;
  logic [NUM_SPRITES-1:0]         collision;
  logic [NUM_SPRITES*COORD_W-1:0] spriteX;
  logic [NUM_SPRITES*COORD_W-1:0] spriteY;
  logic [COORD_W-1:0]             spriteS;
  logic [NUM_SPRITES-1:0]         blocked;

  modport master (
    output keycode, mode, collision,
    input  spriteX, spriteY, spriteS, blocked
  );

  modport slave (
    input  keycode, mode, collision,
    output spriteX, spriteY, spriteS, blocked
  );

endinterface

// File: rtl/sprite_motion_ctrl_axis_unit.sv
// One sprite's mover: key-driven FSM with hold/auto-repeat counter,
// screen clamping and single-step collision undo.
//
//   state   | meaning
//   IDLE    | no key pressed, sprite at rest
//   HELD    | key held; stepping per mode and hold counter
//   BLOCKED | last move reverted by collision; that direction locked out
module sprite_axis_unit
  import sprite_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int SIZE        = 30,
  parameter int STEP        = 1,
  parameter int X_START     = 320,
  parameter int Y_START     = 240,
  parameter int HOLD_FRAMES = 8
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         key_i,
  input  logic               mode_i,
  input  logic               collision_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               blocked_o
);

  localparam int CW1   = COORD_W + 1;
  localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

  localparam logic signed [CW1-1:0] STEP_S = CW1'(STEP);
  localparam logic signed [CW1-1:0] X_LO   = CW1'(X_MIN + SIZE);
  localparam logic signed [CW1-1:0] X_HI   = CW1'(X_MAX - SIZE);
  localparam logic signed [CW1-1:0] Y_LO   = CW1'(Y_MIN + SIZE);
  localparam logic signed [CW1-1:0] Y_HI   = CW1'(Y_MAX - SIZE);
  localparam logic [CNT_W-1:0]      HOLD_TC = CNT_W'(HOLD_FRAMES);
  localparam logic [COORD_W-1:0]    X_RST  = COORD_W'(X_START);
  localparam logic [COORD_W-1:0]    Y_RST  = COORD_W'(Y_START);

  state_e             state_q;
  dir_e               last_dir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] x_q, y_q, px_q, py_q;
  logic               blocked_q;

  dir_e               dir;
  logic signed [CW1-1:0] x_next, y_next;
  logic [COORD_W-1:0] x_step_d, y_step_d;

  assign dir = decode_key(key_i);

  // Candidate position after one step in the current key direction; the
  // extra sign bit keeps a step below zero from wrapping before the clamp.
  always_comb begin
    x_next = $signed({1'b0, x_q});
    y_next = $signed({1'b0, y_q});
    case (dir)
      L:       x_next = x_next - STEP_S;
      R:       x_next = x_next + STEP_S;
      U:       y_next = y_next - STEP_S;
      D:       y_next = y_next + STEP_S;
      default: ;
    endcase
    if (x_next < X_LO)      x_next = X_LO;
    else if (x_next > X_HI) x_next = X_HI;
    if (y_next < Y_LO)      y_next = Y_LO;
    else if (y_next > Y_HI) y_next = Y_HI;
    x_step_d = x_next[COORD_W-1:0];
    y_step_d = y_next[COORD_W-1:0];
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      last_dir_q <= NONE;
      cnt_q      <= '0;
      x_q        <= X_RST;
      y_q        <= Y_RST;
      px_q       <= X_RST;
      py_q       <= Y_RST;
      blocked_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dir != NONE) begin
            px_q       <= x_q;
            py_q       <= y_q;
            x_q        <= x_step_d;
            y_q        <= y_step_d;
            last_dir_q <= dir;
            cnt_q      <= '0;
            state_q    <= HELD;
          end
        end
        HELD: begin
          // The undo takes priority over whatever the key is doing this frame.
          if (collision_i) begin
            x_q       <= px_q;
            y_q       <= py_q;
            state_q   <= BLOCKED;
            blocked_q <= 1'b1;
          end else if (dir == NONE) begin
            state_q <= IDLE;
          end else if (dir != last_dir_q) begin
            px_q       <= x_q;
            py_q       <= y_q;
            x_q        <= x_step_d;
            y_q        <= y_step_d;
            last_dir_q <= dir;
            cnt_q      <= '0;
          end else begin
            if (mode_i || (cnt_q == HOLD_TC)) begin
              px_q <= x_q;
              py_q <= y_q;
              x_q  <= x_step_d;
              y_q  <= y_step_d;
            end
            if (cnt_q != HOLD_TC) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BLOCKED: begin
          if (dir == NONE) begin
            state_q   <= IDLE;
            blocked_q <= 1'b0;
          end else if (dir != last_dir_q) begin
            px_q       <= x_q;
            py_q       <= y_q;
            x_q        <= x_step_d;
            y_q        <= y_step_d;
            last_dir_q <= dir;
            cnt_q      <= '0;
            state_q    <= HELD;
            blocked_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          blocked_q <= 1'b0;
        end
      endcase
    end
  end

  assign x_o       = x_q;
  assign y_o       = y_q;
  assign blocked_o = blocked_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Multi-sprite motion controller: one independent axis unit per sprite,
// with keycode slicing and position packing onto the shared interface.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 2,
  parameter int COORD_W     = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int SIZE        = 30,
  parameter int STEP        = 1,
  parameter int X_START     = 320,
  parameter int Y_START     = 240,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  sprite_motion_ctrl_if.slave  bus
);

  assign bus.spriteS = COORD_W'(SIZE);

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    logic [COORD_W-1:0] x, y;
    logic               blk;

    sprite_axis_unit #(
      .COORD_W    (COORD_W),
      .X_MIN      (X_MIN),
      .X_MAX      (X_MAX),
      .Y_MIN      (Y_MIN),
      .Y_MAX      (Y_MAX),
      .SIZE       (SIZE),
      .STEP       (STEP),
      .X_START    (X_START),
      .Y_START    (Y_START),
      .HOLD_FRAMES(HOLD_FRAMES)
    ) u_axis (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .key_i      (bus.keycode[8*i +: 8]),
      .mode_i     (bus.mode),
      .collision_i(bus.collision[i]),
      .x_o        (x),
      .y_o        (y),
      .blocked_o  (blk)
    );

    assign bus.spriteX[COORD_W*i +: COORD_W] = x;
    assign bus.spriteY[COORD_W*i +: COORD_W] = y;
    assign bus.blocked[i]                    = blk;
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: reset, step/auto-repeat, continuous
// clamping, collision undo and two-sprite independence.
module tb_sprite_motion_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sprite_motion_ctrl_if #(.NUM_SPRITES(2), .COORD_W(10)) bus ();

  sprite_motion_ctrl #(.NUM_SPRITES(2), .COORD_W(10)) dut (
    .frame_clk(clk),
    .Reset    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] x0(); return 32'(bus.spriteX[9:0]);   endfunction
  function automatic logic [31:0] x1(); return 32'(bus.spriteX[19:10]); endfunction
  function automatic logic [31:0] y0(); return 32'(bus.spriteY[9:0]);   endfunction
  function automatic logic [31:0] y1(); return 32'(bus.spriteY[19:10]); endfunction
  function automatic logic [31:0] blk(); return 32'(bus.blocked);       endfunction

  task automatic keys(input logic [7:0] k0, input logic [7:0] k1);
    bus.keycode = {k1, k0};
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.keycode   = '0;
    bus.mode      = 1'b0;
    bus.collision = '0;

    // 1. reset and idle
    tick();
    chk("rst_x0", x0(), 320);
    chk("rst_y0", y0(), 240);
    chk("rst_x1", x1(), 320);
    chk("rst_y1", y1(), 240);
    chk("rst_blk", blk(), 0);
    chk("size", 32'(bus.spriteS), 30);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_x0", x0(), 320);
    chk("idle_y0", y0(), 240);

    // 2. step mode, right held 12 frames
    keys(8'h07, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("step_x0_f%0d", i), x0(), (i <= 9) ? 321 : 321 + (i - 9));
    end
    keys(8'h00, 8'h00);
    repeat (2) tick();
    chk("release_x0", x0(), 324);
    chk("release_x1", x1(), 320);

    // 3. continuous mode, clamp on both X edges
    bus.mode = 1'b1;
    keys(8'h04, 8'h00);
    repeat (292) tick();
    chk("cont_x0_32", x0(), 32);
    tick(); chk("cont_x0_31", x0(), 31);
    tick(); chk("cont_x0_30", x0(), 30);
    tick(); chk("clamp_lo", x0(), 30);
    keys(8'h07, 8'h00);
    repeat (579) tick();
    chk("cont_x0_609", x0(), 609);
    tick(); chk("clamp_hi", x0(), 609);
    keys(8'h00, 8'h00);
    tick();

    // 4. collision undo and blocked direction
    bus.mode = 1'b0;
    keys(8'h1A, 8'h00);
    tick();
    chk("up_y0", y0(), 239);
    chk("up_blk", blk(), 0);
    bus.collision = 2'b01;
    tick();
    chk("undo_y0", y0(), 240);
    chk("undo_blk", blk(), 1);
    bus.collision = 2'b00;
    repeat (2) tick();
    chk("blocked_y0", y0(), 240);
    chk("blocked_blk", blk(), 1);
    keys(8'h16, 8'h00);
    tick();
    chk("down_y0", y0(), 241);
    chk("down_blk", blk(), 0);

    // 5. collision beats a key change; collision in IDLE is ignored
    keys(8'h04, 8'h00);
    bus.collision = 2'b01;
    tick();
    chk("coll_dirchg_x0", x0(), 609);
    chk("coll_dirchg_y0", y0(), 240);
    chk("coll_dirchg_blk", blk(), 1);
    bus.collision = 2'b00;
    keys(8'h00, 8'h00);
    tick();
    chk("to_idle_blk", blk(), 0);
    bus.collision = 2'b01;
    tick();
    chk("coll_idle_x0", x0(), 609);
    chk("coll_idle_y0", y0(), 240);
    chk("coll_idle_blk", blk(), 0);
    bus.collision = 2'b00;

    // 6. two independent sprites
    rst_n = 1'b0;
    tick();
    chk("rst2_x0", x0(), 320);
    rst_n = 1'b1;
    keys(8'h07, 8'h04);
    tick();
    chk("dual_x0", x0(), 321);
    chk("dual_x1", x1(), 319);
    bus.collision = 2'b10;
    tick();
    chk("dual_undo_x0", x0(), 321);
    chk("dual_undo_x1", x1(), 320);
    chk("dual_undo_blk", blk(), 2);
    bus.collision = 2'b00;
    repeat (8) tick();
    chk("dual_rep_x0", x0(), 322);
    chk("dual_rep_x1", x1(), 320);
    chk("dual_rep_blk", blk(), 2);
    rst_n = 1'b0;
    bus.collision = 2'b11;
    tick();
    chk("mid_rst_x0", x0(), 320);
    chk("mid_rst_x1", x1(), 320);
    chk("mid_rst_y1", y1(), 240);
    chk("mid_rst_blk", blk(), 0);
    bus.collision = 2'b00;
    rst_n = 1'b1;
    tick();
    chk("post_rst_x0", x0(), 321);
    chk("post_rst_x1", x1(), 319);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
